mult_wide_acc: RTL and testbench

Post-DSP frame accumulator that sits directly downstream of the registered 54-bit `Z` output of a `MULTADDSUB9X9WIDE` dot-product stage. It sign-extends and sums consecutive `Z` results over a frame delimited by `in_last`. It then scales the frame sum by an arithmetic right shift, saturates it to a signed output width, and presents it on a valid/ready output port backed by a single output register.

---
 rtl/mult_wide_acc.sv | 103 ++++++++++
 tb/tb_mult_wide_acc.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mult_wide_acc.sv
// Frame accumulator for a wide signed DSP Z stream: it sums beats up to in_last,
// shifts the sum, saturates it and holds the result in a single valid/ready output register.
module mult_wide_acc #(
  parameter int DW    = 54,
  parameter int ACC_W = 64,
  parameter int OUT_W = 32,
  parameter int SHIFT = 0,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic {EMPTY, ACCUM} state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;

  logic               acc_en;
  logic               produce;
  logic [ACC_W-1:0]   in_ext;
  logic [ACC_W-1:0]   acc_op;
  logic [CNT_W-1:0]   cnt_op;
  logic [ACC_W-1:0]   sum;
  logic [ACC_W-1:0]   sh;
  logic [ACC_W-OUT_W:0] sh_top;
  logic               in_range;
  logic [CNT_W-1:0]   cnt_inc;
  logic [OUT_W-1:0]   sat_data;
  logic               sat_flag;

  // A stalled output register blocks every beat, not only the last one.
  assign in_ready = !RST && (!out_valid || out_ready);
  assign acc_en   = in_valid && in_ready;
  assign produce  = acc_en && in_last;

  always_comb begin
    in_ext = {ACC_W{in_data[DW-1]}};
    in_ext[DW-1:0] = in_data;
  end

  assign acc_op  = (state == ACCUM) ? acc : '0;
  assign cnt_op  = (state == ACCUM) ? cnt : '0;
  assign sum     = acc_op + in_ext;
  assign sh      = $signed(sum) >>> SHIFT;
  assign cnt_inc = (cnt_op == '1) ? cnt_op : cnt_op + CNT_W'(1);

  // The shifted sum fits when all bits from the output sign bit upward agree.
  assign sh_top   = sh[ACC_W-1:OUT_W-1];
  assign in_range = (sh_top == '0) || (sh_top == '1);

  always_comb begin
    sat_flag = !in_range;
    sat_data = sh[OUT_W-1:0];
    if (!in_range) begin
      if (sh[ACC_W-1]) sat_data = {1'b1, {(OUT_W-1){1'b0}}};
      else             sat_data = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= EMPTY;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_count <= '0;
    end else begin
      if (acc_en) begin
        if (in_last) begin
          state <= EMPTY;
          acc   <= '0;
          cnt   <= '0;
        end else begin
          state <= ACCUM;
          acc   <= sum;
          cnt   <= cnt_inc;
        end
      end
      if (produce) begin
        out_valid <= 1'b1;
        out_data  <= sat_data;
        out_sat   <= sat_flag;
        out_count <= cnt_inc;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mult_wide_acc.sv
// Directed bench for mult_wide_acc: one unshifted instance and one with SHIFT=4
// are driven by the same input stream.
module tb_mult_wide_acc;

  logic               CLK = 1'b0;
  logic               RST;
  logic               in_valid;
  logic signed [53:0] in_data;
  logic               in_last;
  logic               out_ready;

  logic               in_ready, out_valid, out_sat;
  logic [31:0]        out_data;
  logic [7:0]         out_count;

  logic               sh_in_ready, sh_out_valid, sh_out_sat;
  logic [31:0]        sh_out_data;
  logic [7:0]         sh_out_count;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  mult_wide_acc #(.DW(54), .ACC_W(64), .OUT_W(32), .SHIFT(0), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .out_count(out_count)
  );

  mult_wide_acc #(.DW(54), .ACC_W(64), .OUT_W(32), .SHIFT(4), .CNT_W(8)) dut_sh (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(sh_in_ready), .out_valid(sh_out_valid), .out_ready(out_ready),
    .out_data(sh_out_data), .out_sat(sh_out_sat), .out_count(sh_out_count)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic signed [53:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    step();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic test_reset();
    RST = 1'b1; out_ready = 1'b1; idle();
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", out_data); end
    checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL reset_sat got=%b exp=0", out_sat); end
    checks++; if (out_count !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", out_count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    RST = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    drive(54'sd10, 1'b0);
    idle(); step();
    drive(54'sd20, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
    drive(-54'sd5, 1'b1);
    idle();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 32'd25) begin errors++; $display("FAIL basic_data got=%0d exp=25", $signed(out_data)); end
    checks++; if (out_count !== 8'd3) begin errors++; $display("FAIL basic_count got=%0d exp=3", out_count); end
    checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL basic_sat got=%b exp=0", out_sat); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    drive(54'sd1 <<< 40, 1'b0);
    drive(54'sd1 <<< 40, 1'b1);
    idle();
    checks++; if (out_data !== 32'h7FFFFFFF) begin errors++; $display("FAIL sat_pos_data got=%h exp=7fffffff", out_data); end
    checks++; if (out_sat !== 1'b1) begin errors++; $display("FAIL sat_pos_flag got=%b exp=1", out_sat); end
    drive(54'sh20000000000000, 1'b1);
    idle();
    checks++; if (out_data !== 32'h80000000) begin errors++; $display("FAIL sat_neg_data got=%h exp=80000000", out_data); end
    checks++; if (out_sat !== 1'b1) begin errors++; $display("FAIL sat_neg_flag got=%b exp=1", out_sat); end
    checks++; if (out_count !== 8'd1) begin errors++; $display("FAIL sat_neg_count got=%0d exp=1", out_count); end
    step();
  endtask

  task automatic test_shift();
    out_ready = 1'b1;
    drive(-54'sd33, 1'b1);
    idle();
    checks++; if (sh_out_data !== 32'hFFFFFFFD) begin errors++; $display("FAIL shift_data got=%0d exp=-3", $signed(sh_out_data)); end
    checks++; if (sh_out_sat !== 1'b0) begin errors++; $display("FAIL shift_sat got=%b exp=0", sh_out_sat); end
    checks++; if (out_data !== 32'hFFFFFFDF) begin errors++; $display("FAIL shift0_data got=%0d exp=-33", $signed(out_data)); end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(54'sd3, 1'b0);
    drive(54'sd4, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd7) begin errors++; $display("FAIL bp_a_data got=%0d/%b exp=7/1", out_data, out_valid); end
    in_valid = 1'b1; in_data = 54'sd10; in_last = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    step(); step();
    checks++; if (out_data !== 32'd7 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold got=%0d/%b exp=7/1", out_data, out_valid); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_a_taken got=%b exp=0", out_valid); end
    drive(54'sd5, 1'b1);
    idle();
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd15) begin errors++; $display("FAIL bp_b_data got=%0d/%b exp=15/1", out_data, out_valid); end
    checks++; if (out_count !== 8'd2) begin errors++; $display("FAIL bp_b_count got=%0d exp=2", out_count); end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive(54'(i), 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'(i) || out_count !== 8'd1) begin
        errors++;
        $display("FAIL b2b_%0d got=%0d/%b/%0d exp=%0d/1/1", i, out_data, out_valid, out_count, i);
      end
    end
    idle();
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid_frame();
    out_ready = 1'b1;
    drive(54'sd100, 1'b0);
    drive(54'sd200, 1'b0);
    idle();
    RST = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmf_in_ready got=%b exp=0", in_ready); end
    step();
    RST = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmf_no_output got=%b exp=0", out_valid); end
    drive(54'sd5, 1'b1);
    idle();
    checks++; if (out_data !== 32'd5 || out_count !== 8'd1) begin errors++; $display("FAIL rmf_data got=%0d/%0d exp=5/1", out_data, out_count); end
    step();
  endtask

  task automatic test_count_sat();
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) drive(54'sd1, 1'b0);
    drive(54'sd1, 1'b1);
    idle();
    checks++; if (out_count !== 8'd255) begin errors++; $display("FAIL cnt_sat got=%0d exp=255", out_count); end
    checks++; if (out_data !== 32'd257) begin errors++; $display("FAIL cnt_sum got=%0d exp=257", out_data); end
    checks++; if (sh_out_data !== 32'd16) begin errors++; $display("FAIL cnt_shift_sum got=%0d exp=16", sh_out_data); end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_shift();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_frame();
    test_count_sat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
